i2c_bus_pad_ctrl: RTL and testbench
===================================

# i2c_bus_pad_ctrl

Parametrised open-drain I2C pad controller with bus-condition monitoring. It resolves NUM_DEV local drivers onto the shared `scl`/`sda` wires with weak pull-ups, and synchronises and glitch-filters the sampled lines. It also detects START/STOP, tracks bus-busy, and flags arbitration loss and clock stretching per driver. It sits between the I2C master/slave agents and the top-level bus wires, and replaces the fixed single-driver tri-state interface.

## Interface
- NUM_DEV, 2: number of local drivers sharing the bus (1..8)
- FILT_DEPTH, 3: consecutive synchronised samples required before a filtered line changes (1..15)
- pclk  input  1  system clock; all state on its rising edge
- areset  input  1  asynchronous, active-high reset
- scl_o  input  NUM_DEV  per-device SCL output value
- scl_oen  input  NUM_DEV  per-device SCL output enable
- sda_o  input  NUM_DEV  per-device SDA output value
- sda_oen  input  NUM_DEV  per-device SDA output enable
- scl  inout  1  shared serial clock wire
- sda  inout  1  shared serial data wire
- scl_i  output  1  synchronised, filtered SCL
- sda_i  output  1  synchronised, filtered SDA
- start_det  output  1  one-cycle pulse on START or repeated START
- stop_det  output  1  one-cycle pulse on STOP
- bus_busy  output  1  high from START until STOP
- arb_lost  output  NUM_DEV  sticky per-device arbitration-lost flag
- scl_stretch  output  NUM_DEV  per-device "SCL held low by another agent" flag

## Operation
- **Drive resolution.** Device d pulls a line low only when `oen[d]=1 && o[d]=0`. `oen=1, o=1` is a release, so open drain is enforced and the block never drives 1.
  - The line is strong 0 when any device pulls low, otherwise high-Z.
  - A (weak0,weak1) pull-up to 1 sits on each wire.
  - Off-chip agents may also pull the wires low.
- **Intent.** rel_scl[d] = !(scl_oen[d] && !scl_o[d]). rel_sda[d] is defined the same way.
- **Synchroniser.** Two flops per line, reset to 1.
- **Filter.** One counter per line, width clog2(FILT_DEPTH+1), reset to 0.
  - Counter clears when the synchronised value equals the filtered value.
  - Otherwise it increments.
  - On the edge where the count would reach FILT_DEPTH, the filtered output takes the synchronised value and the counter clears.
  - Pulses shorter than FILT_DEPTH pclk cycles are rejected.
- **Edge detection.** Registered previous filtered values scl_q/sda_q, reset to 1.
  - START = scl_q && scl_i && sda_q && !sda_i.
  - STOP = scl_q && scl_i && !sda_q && sda_i.
- **Bus state FSM.** States IDLE, BUSY.
  - IDLE→BUSY on START.
  - BUSY→IDLE on STOP.
  - START while BUSY (repeated START) stays BUSY and still pulses start_det.
  - bus_busy = (state==BUSY).
- **Arbitration.** Evaluated on an SCL rising edge (!scl_q && scl_i) while BUSY. If rel_sda[d] is 1 and sda_i is 0, set arb_lost[d].
  - arb_lost[d] holds until stop_det or reset.
  - If the set and clear conditions coincide, clear wins.
  - Current intent is compared. Drivers change SDA only while SCL is low, so intent is stable across the SCL high phase.
- **Stretch.** Per-device counter rel_cnt[d], saturating at LAT = FILT_DEPTH+2.
  - Clears when rel_scl[d]=0; increments while rel_scl[d]=1.
  - scl_stretch[d] = (rel_cnt[d]==LAT) && !scl_i.
  - The counter masks the filter latency after a device releases SCL.

## Timing
- **Reset values:** scl_i=1, sda_i=1, start_det=0, stop_det=0, bus_busy=0, arb_lost=0, scl_stretch=0. All counters are 0 and the FSM is IDLE.
- **Wire latency:** combinational resolution of wire drive from the inputs.
- **Filter latency:** a wire change stable from edge 0 appears on scl_i/sda_i after edge 2+FILT_DEPTH.
- **Detect latency:** start_det/stop_det are asserted in the cycle the qualifying filtered edge is first visible. bus_busy updates one cycle later.
- **Simultaneous SCL and SDA change** in the same filtered cycle: neither START nor STOP is raised.
- **Reset mid-transfer:** every output returns to its reset value immediately and asynchronously. After release, the bus is treated as IDLE even if SDA is low; no START is reported until the next genuine START.
- **NUM_DEV=1:** arbitration logic is still present. arb_lost[0] can set only when an off-chip agent pulls SDA low.

## Test plan
- **Reset:** assert areset mid-transfer with sda driven low → all outputs at reset values within the same cycle. bus_busy stays 0 after release until a new START.
- **Glitch (FILT_DEPTH=3):** a 2-cycle low pulse on sda with scl high → sda_i stays 1 and no start_det. A 3-cycle-plus low → sda_i falls after edge 5 and start_det pulses once.
- **START / repeated START / STOP sequence:** start_det pulses twice, bus_busy=1 throughout, then stop_det pulses once and bus_busy=0 on the next cycle.
- **Arbitration (NUM_DEV=2):** dev0 releases SDA and dev1 pulls low, then SCL rises → arb_lost=2'b01. It stays set until STOP, then returns to 2'b00.
- **Clock stretch:** dev0 releases SCL while dev1 holds it low for 20 cycles → scl_stretch[0]=1 from LAT cycles after release until scl_i rises. scl_stretch[1]=0 throughout.
- **Open drain:** dev0 with oen=1, o=1 and no other drivers → wire resolves to weak 1, never strong 1. Any device pulling low → wire 0.

Source files
------------

// File: rtl/i2c_bus_pad_ctrl.sv
// Open-drain I2C pad controller: resolves local drivers onto scl/sda, filters the
// sampled lines and monitors START/STOP, bus-busy, arbitration loss and stretching.
`timescale 1ns/1ps
module i2c_bus_pad_ctrl #(
  parameter int NUM_DEV    = 2,
  parameter int FILT_DEPTH = 3
) (
  input  logic               pclk,
  input  logic               areset,
  input  logic [NUM_DEV-1:0] scl_o,
  input  logic [NUM_DEV-1:0] scl_oen,
  input  logic [NUM_DEV-1:0] sda_o,
  input  logic [NUM_DEV-1:0] sda_oen,
  inout  wire                scl,
  inout  wire                sda,
  output logic               scl_i,
  output logic               sda_i,
  output logic               start_det,
  output logic               stop_det,
  output logic               bus_busy,
  output logic [NUM_DEV-1:0] arb_lost,
  output logic [NUM_DEV-1:0] scl_stretch
);

  localparam int CW  = $clog2(FILT_DEPTH + 1);
  localparam int LAT = FILT_DEPTH + 2;
  localparam int RW  = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_DEPTH - 1);
  localparam logic [RW-1:0] REL_MAX  = RW'(LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [NUM_DEV-1:0] rel_scl;
  logic [NUM_DEV-1:0] rel_sda;
  logic [1:0]         line_raw;
  logic [1:0]         line_sync;
  logic [1:0]         line_filt;
  logic               scl_q_reg;
  logic               sda_q_reg;
  logic [1:0]         vld_reg;
  logic               armed_reg;
  logic               scl_rise;
  state_t             state_reg;
  state_t             state_next;

  assign rel_scl = ~(scl_oen & ~scl_o);
  assign rel_sda = ~(sda_oen & ~sda_o);

  // Only ever pull low; a release leaves the wire to the pull-up or off-chip agents.
  assign scl = (&rel_scl) ? 1'bz : 1'b0;
  assign sda = (&rel_sda) ? 1'bz : 1'b0;
  pullup pu_scl (scl);
  pullup pu_sda (sda);

  assign line_raw = {sda, scl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic          s1_reg;
      logic          s2_reg;
      logic          filt_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
          s1_reg   <= 1'b1;
          s2_reg   <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          s1_reg <= line_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= s2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign line_sync[gi] = s2_reg;
      assign line_filt[gi] = filt_reg;
    end
  endgenerate

  assign scl_i = line_filt[0];
  assign sda_i = line_filt[1];

  // armed_reg blocks a false START when SDA is already low as reset releases:
  // it waits for the synchroniser to hold real samples showing SDA high.
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      scl_q_reg <= 1'b1;
      sda_q_reg <= 1'b1;
      vld_reg   <= 2'b00;
      armed_reg <= 1'b0;
      state_reg <= IDLE;
    end else begin
      scl_q_reg <= scl_i;
      sda_q_reg <= sda_i;
      vld_reg   <= {vld_reg[0], 1'b1};
      if (vld_reg[1] && line_sync[1] && sda_i)
        armed_reg <= 1'b1;
      state_reg <= state_next;
    end
  end

  assign start_det = armed_reg && scl_q_reg && scl_i && sda_q_reg && !sda_i;
  assign stop_det  = scl_q_reg && scl_i && !sda_q_reg && sda_i;
  assign scl_rise  = !scl_q_reg && scl_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_det) state_next = BUSY;
      BUSY:    if (stop_det)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus_busy = (state_reg == BUSY);

  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
      logic          arb_reg;
      logic [RW-1:0] rel_cnt_reg;

      // Clear on STOP takes priority over a coincident loss.
      always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
          arb_reg <= 1'b0;
        end else if (stop_det) begin
          arb_reg <= 1'b0;
        end else if (bus_busy && scl_rise && rel_sda[gi] && !sda_i) begin
          arb_reg <= 1'b1;
        end
      end

      always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
          rel_cnt_reg <= '0;
        end else if (!rel_scl[gi]) begin
          rel_cnt_reg <= '0;
        end else if (rel_cnt_reg != REL_MAX) begin
          rel_cnt_reg <= rel_cnt_reg + 1'b1;
        end
      end

      assign arb_lost[gi]    = arb_reg;
      assign scl_stretch[gi] = (rel_cnt_reg == REL_MAX) && !scl_i;
    end
  endgenerate

endmodule

// File: tb/tb_i2c_bus_pad_ctrl.sv
// Self-checking bench for i2c_bus_pad_ctrl: directed bus scenarios plus random
// driver activity, all compared every cycle against a behavioural bus model.
`timescale 1ns/1ps
module tb_i2c_bus_pad_ctrl;

  localparam int ND  = 2;
  localparam int FD  = 3;
  localparam int LAT = FD + 2;
  localparam logic [15:0] WMASK = 16'((1 << FD) - 1);

  logic          pclk = 1'b0;
  logic          areset = 1'b1;
  logic [ND-1:0] scl_o = '1, scl_oen = '0, sda_o = '1, sda_oen = '0;
  logic          ext_scl = 1'b0, ext_sda = 1'b0;
  wire           scl, sda;
  logic          scl_i, sda_i, start_det, stop_det, bus_busy;
  logic [ND-1:0] arb_lost, scl_stretch;

  assign scl = ext_scl ? 1'b0 : 1'bz;
  assign sda = ext_sda ? 1'b0 : 1'bz;

  i2c_bus_pad_ctrl #(.NUM_DEV(ND), .FILT_DEPTH(FD)) dut (
    .pclk(pclk), .areset(areset),
    .scl_o(scl_o), .scl_oen(scl_oen), .sda_o(sda_o), .sda_oen(sda_oen),
    .scl(scl), .sda(sda),
    .scl_i(scl_i), .sda_i(sda_i), .start_det(start_det), .stop_det(stop_det),
    .bus_busy(bus_busy), .arb_lost(arb_lost), .scl_stretch(scl_stretch)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0, n_mis = 0;
  int n_start = 0, n_stop = 0, n_str0 = 0, n_str1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: wire sample history (bit i = sample i+1 edges ago),
  // filtered/previous line values, bus state and per-device flags.
  logic [15:0] h_scl, h_sda;
  logic        mf_scl, mf_sda, mq_scl, mq_sda, m_busy, m_armed;
  logic [ND-1:0] m_arb;
  int          m_rel [ND];
  int          m_edges;

  task automatic model_reset();
    h_scl = '1; h_sda = '1;
    mf_scl = 1; mf_sda = 1; mq_scl = 1; mq_sda = 1;
    m_busy = 0; m_armed = 0; m_arb = '0; m_edges = 0;
    for (int d = 0; d < ND; d++) m_rel[d] = 0;
  endtask

  // A filtered line flips once the last FD synchronised samples all disagree with it.
  function automatic logic filt_next(input logic f, input logic [15:0] h);
    logic [15:0] win;
    win = (h >> 1) & WMASK;
    if (f && win == 16'h0) return 1'b0;
    if (!f && win == WMASK) return 1'b1;
    return f;
  endfunction

  task automatic model_edge();
    logic st, sp, rise, nf_scl, nf_sda;
    logic [ND-1:0] rs, rd;
    rs   = ~(scl_oen & ~scl_o);
    rd   = ~(sda_oen & ~sda_o);
    st   = m_armed && mq_scl && mf_scl && mq_sda && !mf_sda;
    sp   = mq_scl && mf_scl && !mq_sda && mf_sda;
    rise = !mq_scl && mf_scl;
    for (int d = 0; d < ND; d++) begin
      if (sp) m_arb[d] = 1'b0;
      else if (m_busy && rise && rd[d] && !mf_sda) m_arb[d] = 1'b1;
      m_rel[d] = rs[d] ? ((m_rel[d] < LAT) ? m_rel[d] + 1 : LAT) : 0;
    end
    if (st) m_busy = 1'b1;
    else if (sp) m_busy = 1'b0;
    if (m_edges >= 2 && h_sda[1] && mf_sda) m_armed = 1'b1;
    nf_scl = filt_next(mf_scl, h_scl);
    nf_sda = filt_next(mf_sda, h_sda);
    mq_scl = mf_scl; mq_sda = mf_sda;
    mf_scl = nf_scl; mf_sda = nf_sda;
    h_scl = {h_scl[14:0], scl};
    h_sda = {h_sda[14:0], sda};
    if (m_edges < 1000) m_edges++;
  endtask

  task automatic cycle_check();
    logic [ND-1:0] exp_str;
    for (int d = 0; d < ND; d++) exp_str[d] = (m_rel[d] == LAT) && !mf_scl;
    chk("scl_i", scl_i, mf_scl);
    chk("sda_i", sda_i, mf_sda);
    chk("start_det", start_det, m_armed && mq_scl && mf_scl && mq_sda && !mf_sda);
    chk("stop_det", stop_det, mq_scl && mf_scl && !mq_sda && mf_sda);
    chk("bus_busy", bus_busy, m_busy);
    chk("arb_lost", arb_lost, m_arb);
    chk("scl_stretch", scl_stretch, exp_str);
    n_start += start_det; n_stop += stop_det;
    n_str0 += scl_stretch[0]; n_str1 += scl_stretch[1];
  endtask

  task automatic step();
    @(posedge pclk);
    if (!areset) model_edge();
    @(negedge pclk);
    cycle_check();
  endtask

  task automatic drive(input logic [ND-1:0] so, input logic [ND-1:0] soe,
                       input logic [ND-1:0] dq, input logic [ND-1:0] dqe,
                       input logic es, input logic ed);
    scl_o = so; scl_oen = soe; sda_o = dq; sda_oen = dqe;
    ext_scl = es; ext_sda = ed;
    #1;
    chk("scl_wire", scl, !(|(soe & ~so)) && !es);
    chk("sda_wire", sda, !(|(dqe & ~dq)) && !ed);
  endtask

  // dev0 drives both lines (oen=1 always), dev1 and off-chip agents released.
  task automatic bus(input logic c, input logic d, input int n);
    drive({1'b1, c}, 2'b01, {1'b1, d}, 2'b01, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_scl_i"}, scl_i, 1);
    chk({tag, "_sda_i"}, sda_i, 1);
    chk({tag, "_start"}, start_det, 0);
    chk({tag, "_stop"}, stop_det, 0);
    chk({tag, "_busy"}, bus_busy, 0);
    chk({tag, "_arb"}, arb_lost, 0);
    chk({tag, "_stretch"}, scl_stretch, 0);
  endtask

  initial begin
    model_reset();
    @(negedge pclk);
    reset_vals("rst0");
    @(negedge pclk);
    areset = 1'b0;
    bus(1, 1, 10);

    // Open drain: release resolves high, any pull resolves low.
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 0);
    drive(2'b01, 2'b11, 2'b11, 2'b01, 0, 0);
    drive(2'b11, 2'b01, 2'b10, 2'b11, 0, 0);
    bus(1, 1, 8);

    // Glitch rejection, then a real START and STOP from an off-chip agent.
    n_start = 0; n_stop = 0;
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 1);
    repeat (2) step();
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 0);
    repeat (8) step();
    chk("glitch_start_cnt", n_start, 0);
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 1);
    repeat (10) step();
    chk("real_start_cnt", n_start, 1);
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 0);
    repeat (10) step();
    chk("ext_stop_cnt", n_stop, 1);

    // START, repeated START, STOP.
    n_start = 0; n_stop = 0;
    bus(1, 1, 8); bus(1, 0, 8); bus(0, 0, 8); bus(0, 1, 8); bus(1, 1, 8);
    bus(1, 0, 8); bus(0, 0, 8); bus(1, 0, 8); bus(1, 1, 8);
    chk("seq_start_cnt", n_start, 2);
    chk("seq_stop_cnt", n_stop, 1);

    // Arbitration: dev0 releases SDA while dev1 pulls it low, then SCL rises.
    bus(1, 0, 8); bus(0, 0, 8);
    drive(2'b10, 2'b01, 2'b01, 2'b11, 0, 0);
    repeat (8) step();
    drive(2'b11, 2'b01, 2'b01, 2'b11, 0, 0);
    repeat (10) step();
    chk("arb_set", arb_lost, 2'b01);
    drive(2'b11, 2'b01, 2'b11, 2'b01, 0, 0);
    repeat (10) step();
    chk("arb_clear", arb_lost, 2'b00);

    // Clock stretch: dev0 releases SCL, dev1 holds it low for 20 cycles.
    bus(1, 0, 8); bus(0, 0, 8);
    n_str0 = 0; n_str1 = 0;
    drive(2'b01, 2'b11, 2'b10, 2'b01, 0, 0);
    repeat (20) step();
    drive(2'b11, 2'b01, 2'b10, 2'b01, 0, 0);
    repeat (10) step();
    chk("stretch0_cycles", n_str0, 20);
    chk("stretch1_cycles", n_str1, 0);
    bus(1, 0, 2); bus(1, 1, 10);

    // Asynchronous reset mid-transfer with SDA held low.
    bus(1, 0, 10);
    chk("busy_before_rst", bus_busy, 1);
    #2 areset = 1'b1;
    model_reset();
    #1 reset_vals("rst_mid");
    repeat (2) step();
    areset = 1'b0;
    n_start = 0;
    repeat (15) step();
    chk("rst_no_start", n_start, 0);
    chk("rst_busy", bus_busy, 0);
    bus(1, 1, 8); bus(1, 0, 8);
    chk("rst_new_start", n_start, 1);
    bus(1, 1, 10);

    // Random driver activity.
    for (int s = 0; s < 250; s++) begin
      drive(ND'($urandom | $urandom), ND'($urandom), ND'($urandom | $urandom), ND'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(1, 8)) step();
    end
    bus(1, 1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
